// File: rtl/note_sequencer.sv
// ---------------------------------------------------------------------------
// note_sequencer
//
// Generates trigger pulses for one note lane from a chart memory. Each chart
// word holds the number of frames to wait after the previous note. When the
// wait is over, the sequencer sends a one-cycle trigger to a free slot of the
// lane's falling-note block. The sequencer keeps its own count of how long
// each slot stays busy. A slot is free again only after its note has left
// the screen.
//
// Configuration macro: NOTE_SEQ_LOOP_EN
//   defined   - an END word sends playback back to address 0. The chart
//               loops forever and DONE is never reached.
//   undefined - an END word stops playback in DONE.
//
// Parameters:
//   ADDR_W      chart memory address width
//   SLOT_FRAMES frames a slot stays busy after its trigger
//
// Ports:
//   Clk         system clock; all logic runs on its rising edge
//   Reset       asynchronous active-low reset
//   frame_clk   VGA frame clock (vsync-rate level), asynchronous to Clk
//   start       one-cycle pulse; starts playback at address 0
//   chart_data  chart word, valid 1 Clk after chart_addr
//               [15] = END, [14:0] = delay in frames
//   chart_addr  chart read address
//   trigger     one-hot, one-Clk pulses; bit k drives slot k+1
//   busy        high in every state except IDLE and DONE
//   done        high in DONE
//   dropped     sticky; set when a note fires and no slot is free
//   note_count  number of notes triggered since start
// ---------------------------------------------------------------------------
module note_sequencer #(
    parameter int ADDR_W      = 8,
    parameter int SLOT_FRAMES = 97
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              frame_clk,
    input  logic              start,
    input  logic [15:0]       chart_data,
    output logic [ADDR_W-1:0] chart_addr,
    output logic [19:0]       trigger,
    output logic              busy,
    output logic              done,
    output logic              dropped,
    output logic [15:0]       note_count
);

    localparam int NUM_SLOTS = 20;

    typedef enum logic [2:0] {IDLE, FETCH, LOAD, WAIT, FIRE, DONE} state_t;

    state_t               state;
    state_t               next_state;
    logic                 frame_sync1;
    logic                 frame_sync2;
    logic                 frame_prev;
    logic                 tick;
    logic [14:0]          wait_cnt;
    logic [6:0]           slot_cnt [NUM_SLOTS];
    logic [NUM_SLOTS-1:0] free_onehot;
    logic                 any_free;
    logic                 fire_enter;

    // Bring frame_clk into the Clk domain with two flops, then detect its
    // rising edge. The tick is registered, so it is one Clk wide and goes
    // high 3 Clk after frame_clk rises.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            frame_sync1 <= 1'b0;
            frame_sync2 <= 1'b0;
            frame_prev  <= 1'b0;
            tick        <= 1'b0;
        end else begin
            frame_sync1 <= frame_clk;
            frame_sync2 <= frame_sync1;
            frame_prev  <= frame_sync2;
            tick        <= frame_sync2 & ~frame_prev;
        end
    end

    // Find the lowest-numbered free slot. This reads the registered counters.
    // A counter that reaches zero in the current cycle therefore counts as
    // free only from the next cycle on.
    always_comb begin
        free_onehot = '0;
        any_free    = 1'b0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (slot_cnt[k] == 7'd0 && !any_free) begin
                free_onehot[k] = 1'b1;
                any_free       = 1'b1;
            end
        end
    end

    // Slot occupancy timers. They run in every state, so notes that are
    // still on screen stay tracked while the sequencer is idle.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                slot_cnt[k] <= 7'd0;
            end
        end else begin
            for (int k = 0; k < NUM_SLOTS; k++) begin
                if (fire_enter && any_free && free_onehot[k]) begin
                    slot_cnt[k] <= 7'(SLOT_FRAMES);
                end else if (tick && slot_cnt[k] != 7'd0) begin
                    slot_cnt[k] <= slot_cnt[k] - 7'd1;
                end
            end
        end
    end

    // State register.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. The FIRE cycle is the cycle in which trigger is high.
    // The slot is therefore chosen on the edge that enters FIRE.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (start) next_state = FETCH;
            FETCH: next_state = LOAD;
            LOAD: begin
                if (chart_data[15]) begin
`ifdef NOTE_SEQ_LOOP_EN
                    next_state = FETCH;
`else
                    next_state = DONE;
`endif
                end else if (chart_data[14:0] == 15'd0) begin
                    next_state = FIRE;
                end else begin
                    next_state = WAIT;
                end
            end
            WAIT:  if (tick && wait_cnt == 15'd1) next_state = FIRE;
            FIRE:  next_state = FETCH;
            DONE:  if (start) next_state = FETCH;
            default: next_state = IDLE;
        endcase
        fire_enter = (next_state == FIRE);
    end

    // Address, wait counter, trigger and note statistics.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            chart_addr <= '0;
            trigger    <= '0;
            dropped    <= 1'b0;
            note_count <= 16'd0;
            wait_cnt   <= 15'd0;
        end else begin
            trigger <= '0;
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        chart_addr <= '0;
                        note_count <= 16'd0;
                        dropped    <= 1'b0;
                    end
                end
                LOAD: begin
                    if (chart_data[15]) begin
`ifdef NOTE_SEQ_LOOP_EN
                        chart_addr <= '0;
`endif
                    end else begin
                        wait_cnt <= chart_data[14:0];
                    end
                end
                WAIT: begin
                    if (tick) wait_cnt <= wait_cnt - 15'd1;
                end
                FIRE: chart_addr <= chart_addr + ADDR_W'(1);
                default: ;
            endcase
            if (fire_enter) begin
                if (any_free) begin
                    trigger    <= free_onehot;
                    note_count <= note_count + 16'd1;
                end else begin
                    dropped <= 1'b1;
                end
            end
        end
    end

    assign busy = (state != IDLE) && (state != DONE);
    assign done = (state == DONE);

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Chart-driven trigger generator for one note lane: reads a chart memory of inter-note frame delays and issues one-cycle trigger pulses to the 20 note slots of the lane's falling-note block. Sits between chart ROM and the note lane. Tracks slot occupancy locally so each trigger goes to a slot whose note has left the screen. Counts frames from the VGA frame clock.

## Interface
- ADDR_W, 8, chart memory address width
- SLOT_FRAMES, 97, frames a slot stays busy after its trigger (96 frames at 5 px/frame to reach Y≥479, plus 1 frame for Y to return to 0)
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  asynchronous, active-low reset
- frame_clk  in  1  VGA frame clock (vsync-rate level signal), asynchronous to Clk
- start  in  1  one-cycle pulse; begins playback from address 0
- chart_data  in  16  chart word, valid 1 Clk after chart_addr; [15]=END, [14:0]=delay in frames since previous note
- chart_addr  out  ADDR_W  chart read address
- trigger  out  20  one-hot, one-Clk pulses; bit k drives slot k+1 trigger input
- busy  out  1  high in any state except IDLE/DONE
- done  out  1  high in DONE
- dropped  out  1  sticky; set when a note fires with no free slot
- note_count  out  16  notes successfully triggered since start

## Operation
- Frame tick: frame_clk through 2-flop synchronizer, then rising-edge detect → tick, one Clk wide, 3 Clk after frame_clk rises.
- Slot tracker: 20 counters, 7 bits each. On trigger to slot k, counter k loads SLOT_FRAMES. On tick, each non-zero counter decrements. Slot free ⇔ counter == 0. Load takes priority over decrement in the same cycle.
- FSM states: IDLE, FETCH, LOAD, WAIT, FIRE, DONE.
  - IDLE: wait for start → FETCH, with chart_addr=0, note_count=0, dropped=0.
  - FETCH: chart_addr stable; 1-cycle read latency → LOAD.
  - LOAD: capture chart_data. If END=1 → DONE. Otherwise, if delay==0 → FIRE; else load wait counter with delay → WAIT.
  - WAIT: decrement wait counter on each tick; on the tick that takes it to 0 → FIRE.
  - FIRE: select the lowest-index free slot, pulse its trigger bit, note_count+1. If no slot is free, no pulse, set dropped, note_count unchanged. In both cases chart_addr+1 (wraps from 2^ADDR_W−1 to 0) → FETCH.
  - DONE: hold; start → FETCH from address 0, clearing note_count and dropped.
- start in any state other than IDLE/DONE is ignored.
- Slot counters keep running in every state, including DONE and IDLE, so notes already on screen are tracked.
- A slot whose counter reaches 0 on the current cycle becomes eligible on the next cycle, not the same one.

## Timing
- Reset (asserted): state=IDLE, chart_addr=0, trigger=0, busy=0, done=0, dropped=0, note_count=0, all slot counters=0, synchronizer flops=0.
- Reset asserted mid-playback: all outputs clear asynchronously. Any trigger pulse in flight is cut.
- Fetch-to-trigger latency for a delay-0 entry: FETCH→LOAD→FIRE, so trigger asserts 2 Clk after FETCH entry.
- Delay d>0: trigger asserts 1 Clk after the d-th tick following LOAD.
- trigger is registered; at most one bit high per cycle; never high for two consecutive cycles.
- Consecutive delay-0 entries fire every 3 Clk (FIRE→FETCH→LOAD→FIRE).

## Configuration
- NOTE_SEQ_LOOP_EN defined: an END word in LOAD sets chart_addr=0 and goes → FETCH (endless loop). DONE is unreachable. note_count and dropped are not cleared by the wrap.
- Undefined: END → DONE as described above.

## Test plan
- Chart {delay 2, delay 0, END}; start; 5 ticks:
  - trigger[0] pulses after tick 2, then trigger[1] 3 Clk later.
  - done=1, note_count=2, dropped=0.
- Chart of 21 delay-0 entries + END:
  - trigger[0]..trigger[19] pulse in order.
  - 21st note: no pulse, dropped=1, note_count=20.
- Chart {delay 0, delay 97, delay 0}:
  - Slot 0 counter reaches 0 on the tick that also ends the wait, so the second note takes slot 1.
  - The third note, 3 Clk later, takes slot 0.
- Reset deasserted-to-asserted during WAIT with 3 slots busy:
  - All outputs 0, all slots free.
  - After release, start → first trigger goes to trigger[0].
- start pulsed during WAIT: ignored, wait count unaffected.
- With NOTE_SEQ_LOOP_EN and chart {delay 1, END}: trigger pulses on every tick (per the wait/fire timing), chart_addr cycles 0,1,0,…, done stays 0.
